// File: rtl/rx_arp_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_arp_parser_if
// Description : RX byte-stream bundle feeding the ARP request detector.
//               RX_DATA  - frame byte
//               RX_VALID - RX_DATA valid this cycle (no backpressure)
//               RX_LAST  - final byte of the frame, qualified by RX_VALID
//               RX_ERR   - frame error, sampled on any valid beat
//               master drives the stream, slave consumes it.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_arp_parser_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_LAST;
    logic       RX_ERR;

    modport master (output RX_DATA, output RX_VALID, output RX_LAST, output RX_ERR);
    modport slave  (input  RX_DATA, input  RX_VALID, input  RX_LAST, input  RX_ERR);
endinterface
`default_nettype wire

// File: rtl/rx_arp_parser.sv
`default_nettype none
// ============================================================================
// Module      : rx_arp_parser
// Description : Receive-side ARP request detector. Parses frames starting at
//               the destination MAC and, when a well-formed ARP request for
//               FPGA_IP arrives, latches the requester MAC/IP and pulses
//               TRIG_TX_ARP for one cycle after the last byte.
// Ports       : CLK_125M    - RX byte clock
//               SYS_RST     - synchronous active-high reset
//               rx          - RX byte stream (slave modport)
//               TRIG_TX_ARP - one-cycle pulse: request accepted
//               PC_MAC      - sender MAC of last accepted request
//               PC_IP       - sender IP of last accepted request
//               ARP_REQ_CNT - accepted request count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module rx_arp_parser #(
    parameter logic [47:0] FPGA_MAC = 48'h00D0_0800_0002,
    parameter logic [31:0] FPGA_IP  = 32'hC0A8_006E
) (
    input  wire logic         CLK_125M,
    input  wire logic         SYS_RST,
    rx_arp_parser_if.slave    rx,
    output logic              TRIG_TX_ARP,
    output logic [47:0]       PC_MAC,
    output logic [31:0]       PC_IP,
    output logic [15:0]       ARP_REQ_CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PARSE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  byte_cnt;
    logic        match;
    logic        err_seen;
    logic        dst_bc;       // destination bytes so far all 0xFF
    logic        dst_me;       // destination bytes so far equal FPGA_MAC
    logic [47:0] shadow_mac;
    logic [31:0] shadow_ip;
    logic [15:0] req_cnt;

    logic [7:0]  mac_byte;
    logic [7:0]  ip_byte;
    logic        bc_next;
    logic        me_next;
    logic        byte_ok;
    logic        match_now;
    logic        err_now;
    logic        accept;

    // Byte counter, match flag and destination flags are all returned to
    // their start-of-frame values at every frame end, so the IDLE byte is
    // simply index 0 with no special casing.
    always_comb begin
        mac_byte = 8'h00;
        case (byte_cnt)
            6'd0:    mac_byte = FPGA_MAC[47:40];
            6'd1:    mac_byte = FPGA_MAC[39:32];
            6'd2:    mac_byte = FPGA_MAC[31:24];
            6'd3:    mac_byte = FPGA_MAC[23:16];
            6'd4:    mac_byte = FPGA_MAC[15:8];
            6'd5:    mac_byte = FPGA_MAC[7:0];
            default: mac_byte = 8'h00;
        endcase

        ip_byte = 8'h00;
        case (byte_cnt)
            6'd38:   ip_byte = FPGA_IP[31:24];
            6'd39:   ip_byte = FPGA_IP[23:16];
            6'd40:   ip_byte = FPGA_IP[15:8];
            6'd41:   ip_byte = FPGA_IP[7:0];
            default: ip_byte = 8'h00;
        endcase

        bc_next = dst_bc && (rx.RX_DATA == 8'hFF);
        me_next = dst_me && (rx.RX_DATA == mac_byte);

        byte_ok = 1'b1;
        case (byte_cnt)
            6'd0, 6'd1, 6'd2,
            6'd3, 6'd4, 6'd5:    byte_ok = bc_next || me_next;
            6'd12:               byte_ok = (rx.RX_DATA == 8'h08);
            6'd13:               byte_ok = (rx.RX_DATA == 8'h06);
            6'd14:               byte_ok = (rx.RX_DATA == 8'h00);
            6'd15:               byte_ok = (rx.RX_DATA == 8'h01);
            6'd16:               byte_ok = (rx.RX_DATA == 8'h08);
            6'd17:               byte_ok = (rx.RX_DATA == 8'h00);
            6'd18:               byte_ok = (rx.RX_DATA == 8'h06);
            6'd19:               byte_ok = (rx.RX_DATA == 8'h04);
            6'd20:               byte_ok = (rx.RX_DATA == 8'h00);
            6'd21:               byte_ok = (rx.RX_DATA == 8'h01);
            6'd38, 6'd39,
            6'd40, 6'd41:        byte_ok = (rx.RX_DATA == ip_byte);
            default:             byte_ok = 1'b1;
        endcase

        match_now = match && byte_ok;
        err_now   = err_seen || rx.RX_ERR;
        // Sender fields sit at 22..31, so any last beat at index >= 41 has
        // already shifted the complete sender MAC/IP into the shadows.
        accept    = (state != DRAIN) && match_now && !err_now
                    && (byte_cnt >= 6'd41);
    end

    always_ff @(posedge CLK_125M) begin
        if (SYS_RST) begin
            state       <= IDLE;
            byte_cnt    <= 6'd0;
            match       <= 1'b1;
            err_seen    <= 1'b0;
            dst_bc      <= 1'b1;
            dst_me      <= 1'b1;
            shadow_mac  <= 48'd0;
            shadow_ip   <= 32'd0;
            req_cnt     <= 16'd0;
            TRIG_TX_ARP <= 1'b0;
            PC_MAC      <= 48'd0;
            PC_IP       <= 32'd0;
        end else begin
            TRIG_TX_ARP <= 1'b0;
            if (rx.RX_VALID) begin
                if (rx.RX_LAST) begin
                    if (accept) begin
                        TRIG_TX_ARP <= 1'b1;
                        PC_MAC      <= shadow_mac;
                        PC_IP       <= shadow_ip;
                        req_cnt     <= req_cnt + 16'd1;
                    end
                    state    <= IDLE;
                    byte_cnt <= 6'd0;
                    match    <= 1'b1;
                    err_seen <= 1'b0;
                    dst_bc   <= 1'b1;
                    dst_me   <= 1'b1;
                end else if (state != DRAIN) begin
                    if (byte_cnt >= 6'd22 && byte_cnt <= 6'd27)
                        shadow_mac <= {shadow_mac[39:0], rx.RX_DATA};
                    if (byte_cnt >= 6'd28 && byte_cnt <= 6'd31)
                        shadow_ip  <= {shadow_ip[23:0], rx.RX_DATA};

                    byte_cnt <= (byte_cnt == 6'd63) ? 6'd63 : byte_cnt + 6'd1;
                    match    <= match_now;
                    err_seen <= err_now;
                    dst_bc   <= bc_next;
                    dst_me   <= me_next;

                    // Byte 0 always enters PARSE; a failure seen there is
                    // carried in match/err_seen and diverts on the next beat.
                    if (state == PARSE && (!match_now || err_now))
                        state <= DRAIN;
                    else
                        state <= PARSE;
                end
            end
        end
    end

    assign ARP_REQ_CNT = req_cnt;

endmodule
`default_nettype wire
